// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the CDB between ALU and LSB results through per-source FIFOs
// with a round-robin single-grant-per-cycle arbiter and registered broadcast outputs.
module cdb_arbiter #(
    parameter int ROB_WIDTH  = 4,
    parameter int FIFO_WIDTH = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear_in,
    input  logic                 alu_valid,
    input  logic [ROB_WIDTH-1:0] alu_tag,
    input  logic [31:0]          alu_data,
    output logic                 alu_full,
    input  logic                 lsb_valid,
    input  logic [ROB_WIDTH-1:0] lsb_tag,
    input  logic [31:0]          lsb_data,
    output logic                 lsb_full,
    output logic                 cdb_valid,
    output logic                 cdb_src,
    output logic [ROB_WIDTH-1:0] cdb_tag,
    output logic [31:0]          cdb_data
);
    logic [ROB_WIDTH-1:0]  r_alu_tag_q  [FIFO_DEPTH];
    logic [31:0]           r_alu_data_q [FIFO_DEPTH];
    logic [ROB_WIDTH-1:0]  r_lsb_tag_q  [FIFO_DEPTH];
    logic [31:0]           r_lsb_data_q [FIFO_DEPTH];
    logic [FIFO_WIDTH-1:0] r_alu_head, r_alu_tail, r_lsb_head, r_lsb_tail;
    logic [FIFO_WIDTH:0]   r_alu_cnt, r_lsb_cnt;
    logic                  r_rr;

    logic                  w_alu_ne, w_lsb_ne, w_grant, w_sel;
    logic                  w_alu_pop, w_lsb_pop, w_alu_push, w_lsb_push;
    logic [FIFO_WIDTH:0]   w_alu_cnt_nxt, w_lsb_cnt_nxt;

    // Arbitration looks only at entries present before this edge's push.
    always_comb begin
        w_alu_ne      = r_alu_cnt != '0;
        w_lsb_ne      = r_lsb_cnt != '0;
        w_grant       = w_alu_ne | w_lsb_ne;
        w_sel         = (w_alu_ne & w_lsb_ne) ? r_rr : w_lsb_ne;
        w_alu_pop     = w_grant & ~w_sel;
        w_lsb_pop     = w_grant & w_sel;
        w_alu_push    = alu_valid & ~alu_full;
        w_lsb_push    = lsb_valid & ~lsb_full;
        w_alu_cnt_nxt = r_alu_cnt + (FIFO_WIDTH+1)'(w_alu_push) - (FIFO_WIDTH+1)'(w_alu_pop);
        w_lsb_cnt_nxt = r_lsb_cnt + (FIFO_WIDTH+1)'(w_lsb_push) - (FIFO_WIDTH+1)'(w_lsb_pop);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || (rdy_in && clear_in)) begin
            r_alu_head <= '0;
            r_alu_tail <= '0;
            r_alu_cnt  <= '0;
            r_lsb_head <= '0;
            r_lsb_tail <= '0;
            r_lsb_cnt  <= '0;
            r_rr       <= 1'b0;
            alu_full   <= 1'b0;
            lsb_full   <= 1'b0;
            cdb_valid  <= 1'b0;
            cdb_src    <= 1'b0;
            cdb_tag    <= '0;
            cdb_data   <= '0;
        end else if (rdy_in) begin
            if (w_alu_push) begin
                r_alu_tag_q[r_alu_tail]  <= alu_tag;
                r_alu_data_q[r_alu_tail] <= alu_data;
                r_alu_tail               <= r_alu_tail + 1'b1;
            end
            if (w_lsb_push) begin
                r_lsb_tag_q[r_lsb_tail]  <= lsb_tag;
                r_lsb_data_q[r_lsb_tail] <= lsb_data;
                r_lsb_tail               <= r_lsb_tail + 1'b1;
            end
            if (w_alu_pop) r_alu_head <= r_alu_head + 1'b1;
            if (w_lsb_pop) r_lsb_head <= r_lsb_head + 1'b1;
            r_alu_cnt <= w_alu_cnt_nxt;
            r_lsb_cnt <= w_lsb_cnt_nxt;
            alu_full  <= w_alu_cnt_nxt == (FIFO_WIDTH+1)'(FIFO_DEPTH);
            lsb_full  <= w_lsb_cnt_nxt == (FIFO_WIDTH+1)'(FIFO_DEPTH);
            cdb_valid <= w_grant;
            if (w_grant) begin
                r_rr     <= ~w_sel;
                cdb_src  <= w_sel;
                cdb_tag  <= w_sel ? r_lsb_tag_q[r_lsb_head]  : r_alu_tag_q[r_alu_head];
                cdb_data <= w_sel ? r_lsb_data_q[r_lsb_head] : r_alu_data_q[r_alu_head];
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed checks of the CDB arbiter with hand-computed expectations.
module tb_cdb_arbiter;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        clear_in = 1'b0;
    logic        alu_valid = 1'b0;
    logic [3:0]  alu_tag = '0;
    logic [31:0] alu_data = '0;
    logic        alu_full;
    logic        lsb_valid = 1'b0;
    logic [3:0]  lsb_tag = '0;
    logic [31:0] lsb_data = '0;
    logic        lsb_full;
    logic        cdb_valid;
    logic        cdb_src;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;

    int n_vec = 0;
    int n_err = 0;

    cdb_arbiter #(.ROB_WIDTH(4), .FIFO_WIDTH(2), .FIFO_DEPTH(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .alu_valid(alu_valid), .alu_tag(alu_tag), .alu_data(alu_data), .alu_full(alu_full),
        .lsb_valid(lsb_valid), .lsb_tag(lsb_tag), .lsb_data(lsb_data), .lsb_full(lsb_full),
        .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_tag(cdb_tag), .cdb_data(cdb_data)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic s,
                           input logic [3:0] t, input logic [31:0] d);
        chk({tag, ".valid"}, 32'(cdb_valid), 32'(v));
        if (v) begin
            chk({tag, ".src"}, 32'(cdb_src), 32'(s));
            chk({tag, ".tag"}, 32'(cdb_tag), 32'(t));
            chk({tag, ".data"}, cdb_data, d);
        end
    endtask

    task automatic push(input logic av, input logic [3:0] at, input logic [31:0] ad,
                        input logic lv, input logic [3:0] lt, input logic [31:0] ld);
        alu_valid = av; alu_tag = at; alu_data = ad;
        lsb_valid = lv; lsb_tag = lt; lsb_data = ld;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    // Sustained contention: expected outputs after edge k (see hand trace).
    logic        e_v  [18] = '{0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0};
    logic        e_s  [18] = '{0,0,1,0,1,0,1,0,1,0,1,0,1,0,1,0,1,0};
    int          e_d  [18] = '{0,0,0,1,1,2,2,3,3,4,4,5,5,6,7,8,9,0};
    logic        e_af [18] = '{0,0,0,0,0,0,1,0,1,0,0,0,0,0,0,0,0,0};
    logic        e_lf [18] = '{0,0,0,0,0,1,0,1,0,1,0,0,0,0,0,0,0,0};

    initial begin
        do_reset();
        chk("rst.valid", 32'(cdb_valid), 0);
        chk("rst.src", 32'(cdb_src), 0);
        chk("rst.tag", 32'(cdb_tag), 0);
        chk("rst.data", cdb_data, 0);
        chk("rst.afull", 32'(alu_full), 0);
        chk("rst.lfull", 32'(lsb_full), 0);

        // single ALU push: two edges of latency, one cycle of valid
        push(1, 4'd3, 32'h11, 0, 0, 0);
        tick();
        push(0, 0, 0, 0, 0, 0);
        chk_out("lat.e1", 0, 0, 0, 0);
        tick();
        chk_out("lat.e2", 1, 0, 4'd3, 32'h11);
        tick();
        chk_out("lat.e3", 0, 0, 0, 0);
        chk("lat.hold_tag", 32'(cdb_tag), 3);

        // simultaneous pairs from a fresh reset: ALU first each time
        do_reset();
        push(1, 4'd1, 32'hA, 1, 4'd2, 32'hB);
        tick();
        push(0, 0, 0, 0, 0, 0);
        tick();
        chk_out("pair1.a", 1, 0, 4'd1, 32'hA);
        tick();
        chk_out("pair1.b", 1, 1, 4'd2, 32'hB);
        tick();
        chk_out("pair1.idle", 0, 0, 0, 0);
        push(1, 4'd4, 32'hC, 1, 4'd5, 32'hD);
        tick();
        push(0, 0, 0, 0, 0, 0);
        tick();
        chk_out("pair2.a", 1, 0, 4'd4, 32'hC);
        tick();
        chk_out("pair2.b", 1, 1, 4'd5, 32'hD);
        tick();
        chk_out("pair2.idle", 0, 0, 0, 0);

        // both sources push every cycle for 10 cycles, then drain
        for (int k = 0; k < 18; k++) begin
            if (k < 10) push(1, 4'(k), 32'(k), 1, 4'(k), 32'(k));
            else push(0, 0, 0, 0, 0, 0);
            tick();
            chk_out($sformatf("rr.e%0d", k), e_v[k], e_s[k], 4'(e_d[k]), 32'(e_d[k]));
            chk($sformatf("rr.afull%0d", k), 32'(alu_full), 32'(e_af[k]));
            chk($sformatf("rr.lfull%0d", k), 32'(lsb_full), 32'(e_lf[k]));
        end

        // LSB stream of six tags wraps the circular pointers
        for (int k = 0; k < 8; k++) begin
            if (k < 6) push(0, 0, 0, 1, 4'(k), 32'h100 + 32'(k));
            else push(0, 0, 0, 0, 0, 0);
            tick();
            if (k == 0) chk_out("wrap.e0", 0, 0, 0, 0);
            else if (k < 7) chk_out($sformatf("wrap.e%0d", k), 1, 1, 4'(k-1), 32'h100 + 32'(k-1));
            else chk_out("wrap.end", 0, 0, 0, 0);
        end

        // three entries queued, then clear alongside a new ALU push
        push(1, 4'd1, 32'h21, 1, 4'd2, 32'h22);
        tick();
        push(1, 4'd3, 32'h23, 1, 4'd4, 32'h24);
        tick();
        chk_out("clr.pre", 1, 0, 4'd1, 32'h21);
        push(1, 4'd5, 32'h25, 0, 0, 0);
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        push(0, 0, 0, 0, 0, 0);
        chk_out("clr.e0", 0, 0, 0, 0);
        chk("clr.tag", 32'(cdb_tag), 0);
        chk("clr.data", cdb_data, 0);
        chk("clr.afull", 32'(alu_full), 0);
        chk("clr.lfull", 32'(lsb_full), 0);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk_out($sformatf("clr.e%0d", k), 0, 0, 0, 0);
        end

        // rdy_in low freezes everything, including pushes presented meanwhile
        push(1, 4'd6, 32'h66, 1, 4'd7, 32'h77);
        tick();
        push(0, 0, 0, 0, 0, 0);
        tick();
        chk_out("stall.pre", 1, 0, 4'd6, 32'h66);
        rdy_in = 1'b0;
        push(1, 4'd8, 32'h88, 1, 4'd9, 32'h99);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_out($sformatf("stall.s%0d", k), 1, 0, 4'd6, 32'h66);
        end
        rdy_in = 1'b1;
        push(0, 0, 0, 0, 0, 0);
        tick();
        chk_out("stall.resume", 1, 1, 4'd7, 32'h77);
        tick();
        chk_out("stall.idle", 0, 0, 0, 0);
        chk("stall.afull", 32'(alu_full), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
